// File: rtl/throw_force_meter_if.sv
// Player-side signal bundle of the throw force meter: button/turn inputs,
// force and handshake outputs toward the trajectory controller and HUD.
interface throw_force_meter_if;
   logic       turn_active;
   logic       btn;
   logic [9:0] throw_force;
   logic       enable;
   logic       charging;
   logic       throw_done;

   modport master (
      output turn_active, btn,
      input  throw_force, enable, charging, throw_done
   );

   modport slave (
      input  turn_active, btn,
      output throw_force, enable, charging, throw_done
   );
endinterface

// File: rtl/throw_force_meter.sv
// Charge-and-release throw force meter: sweeps force while the button is held,
// latches it on release for a flight window, then cools down before re-arming.
module throw_force_meter #(
   parameter int unsigned TICK_DIV       = 65000,
   parameter int unsigned FORCE_STEP     = 2,
   parameter int unsigned FORCE_MAX      = 1000,
   parameter int unsigned FLIGHT_TICKS   = 3000,
   parameter int unsigned COOLDOWN_TICKS = 500
) (
   input logic                clk,
   input logic                rst,
   throw_force_meter_if.slave tfm
);

   localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CMAX = (FLIGHT_TICKS > COOLDOWN_TICKS) ? FLIGHT_TICKS : COOLDOWN_TICKS;
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0] FLIGHT_LAST = CW'(FLIGHT_TICKS - 1);
   localparam logic [CW-1:0] COOL_LAST   = CW'(COOLDOWN_TICKS - 1);
   localparam logic [10:0]   STEP11      = 11'(FORCE_STEP);
   localparam logic [10:0]   MAX11       = 11'(FORCE_MAX);
   localparam logic [9:0]    MAX10       = 10'(FORCE_MAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHARGE,
      S_FLIGHT,
      S_COOLDOWN
   } state_t;

   logic          btn_m_q, btn_s_q, btn_d_q;
   logic [1:0]    fill_q;
   logic          arm_q;
   logic [TW-1:0] tick_cnt_q;
   logic          tick, rise, fall;

   state_t        state_q, state_d;
   logic [9:0]    force_q, force_d;
   logic          dir_q, dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          enable_q, enable_d;
   logic          charging_q, charging_d;
   logic          done_q, done_d;
   logic [10:0]   sum11;

   // A button already held at reset release must be seen released once
   // (after the synchronizer has filled) before a press can start a charge.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_m_q <= 1'b0;
         btn_s_q <= 1'b0;
         btn_d_q <= 1'b0;
         fill_q  <= '0;
         arm_q   <= 1'b0;
      end else begin
         btn_m_q <= tfm.btn;
         btn_s_q <= btn_m_q;
         btn_d_q <= btn_s_q;
         if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
         if (fill_q == 2'd2 && !btn_s_q) arm_q <= 1'b1;
      end
   end

   assign rise = btn_s_q & ~btn_d_q & arm_q;
   assign fall = ~btn_s_q & btn_d_q;
   assign tick = (tick_cnt_q == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst) tick_cnt_q <= '0;
      else     tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      force_d = force_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      sum11   = {1'b0, force_q} + STEP11;

      case (state_q)
         S_IDLE: begin
            force_d = '0;
            if (rise && tfm.turn_active) begin
               state_d = S_CHARGE;
               dir_d   = 1'b0;
            end
         end
         S_CHARGE: begin
            if (!tfm.turn_active) begin
               state_d = S_IDLE;
               force_d = '0;
               dir_d   = 1'b0;
            end else if (fall) begin
               state_d = S_FLIGHT;
               cnt_d   = '0;
            end else if (tick) begin
               if (!dir_q) begin
                  if (sum11 >= MAX11) begin
                     force_d = MAX10;
                     dir_d   = 1'b1;
                  end else begin
                     force_d = sum11[9:0];
                  end
               end else if ({1'b0, force_q} <= STEP11) begin
                  force_d = '0;
                  dir_d   = 1'b0;
               end else begin
                  force_d = 10'(sum11 - STEP11 - STEP11);
               end
            end
         end
         S_FLIGHT: begin
            if (tick) begin
               if (cnt_q == FLIGHT_LAST) begin
                  state_d = S_COOLDOWN;
                  cnt_d   = '0;
                  force_d = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_COOLDOWN: begin
            force_d = '0;
            if (tick) begin
               if (cnt_q == COOL_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            force_d = '0;
            dir_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase

      enable_d   = (state_d == S_FLIGHT);
      charging_d = (state_d == S_CHARGE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         force_q    <= '0;
         dir_q      <= 1'b0;
         cnt_q      <= '0;
         enable_q   <= 1'b0;
         charging_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         force_q    <= force_d;
         dir_q      <= dir_d;
         cnt_q      <= cnt_d;
         enable_q   <= enable_d;
         charging_q <= charging_d;
         done_q     <= done_d;
      end
   end

   assign tfm.throw_force = force_q;
   assign tfm.enable      = enable_q;
   assign tfm.charging    = charging_q;
   assign tfm.throw_done  = done_q;

endmodule

// File: tb/tb_throw_force_meter.sv
// Directed bench for throw_force_meter: two instances (step 100 and step 300)
// sharing clock and reset; tick phase is tracked by a bench-side edge counter.
module tb_throw_force_meter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ecnt = 0;
   int   total = 0;
   int   bad = 0;

   throw_force_meter_if if1 ();
   throw_force_meter_if if5 ();

   throw_force_meter #(
      .TICK_DIV(4), .FORCE_STEP(100), .FORCE_MAX(1000),
      .FLIGHT_TICKS(5), .COOLDOWN_TICKS(3)
   ) u_dut (
      .clk(clk), .rst(rst), .tfm(if1)
   );

   throw_force_meter #(
      .TICK_DIV(4), .FORCE_STEP(300), .FORCE_MAX(1000),
      .FLIGHT_TICKS(5), .COOLDOWN_TICKS(3)
   ) u_dut5 (
      .clk(clk), .rst(rst), .tfm(if5)
   );

   always #5 clk = ~clk;

   // Edges where ecnt becomes a multiple of 4 are tick edges.
   always @(posedge clk) begin
      if (rst) ecnt <= 0;
      else     ecnt <= ecnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(negedge clk); while (ecnt % 4 != 0);
      end
   endtask

   int sweep1 [12] = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000, 900, 800};
   int sweep5 [14] = '{300, 600, 900, 1000, 700, 400, 100, 0, 300, 600, 900, 1000, 700, 400};

   initial begin
      if1.turn_active = 1'b1;
      if1.btn         = 1'b1;
      if5.turn_active = 1'b1;
      if5.btn         = 1'b0;

      // 1: reset with button held
      cyc(3);
      check("rst_force", 32'(if1.throw_force), 0);
      check("rst_enable", 32'(if1.enable), 0);
      check("rst_charging", 32'(if1.charging), 0);
      check("rst_done", 32'(if1.throw_done), 0);
      rst = 1'b0;
      cyc(10);
      check("held_after_rst", 32'(if1.charging), 0);
      if1.btn = 1'b0;
      cyc(3);

      // 2: press, sweep for 12 ticks, release
      if1.btn = 1'b1;
      cyc(2);
      check("press_lat2", 32'(if1.charging), 0);
      cyc(1);
      check("press_lat3", 32'(if1.charging), 1);
      check("charge_force0", 32'(if1.throw_force), 0);
      for (int i = 0; i < 12; i++) begin
         wait_ticks(1);
         check($sformatf("sweep1_%0d", i + 1), 32'(if1.throw_force), 32'(sweep1[i]));
      end
      if1.btn = 1'b0;
      cyc(2);
      check("rel_lat2_en", 32'(if1.enable), 0);
      check("rel_lat2_chg", 32'(if1.charging), 1);
      cyc(1);
      check("rel_en", 32'(if1.enable), 1);
      check("rel_force", 32'(if1.throw_force), 800);
      check("rel_chg", 32'(if1.charging), 0);

      // 3: flight, done pulse, cooldown, re-arm
      if1.btn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wait_ticks(1);
         check($sformatf("flight_en_%0d", i), 32'(if1.enable), 1);
         check($sformatf("flight_force_%0d", i), 32'(if1.throw_force), 800);
         if (i == 2) if1.btn = 1'b0;
         if (i == 3) if1.btn = 1'b1;
      end
      wait_ticks(1);
      check("flight_end_en", 32'(if1.enable), 0);
      check("flight_end_done", 32'(if1.throw_done), 1);
      check("flight_end_force", 32'(if1.throw_force), 0);
      check("flight_end_chg", 32'(if1.charging), 0);
      cyc(1);
      check("done_one_cycle", 32'(if1.throw_done), 0);
      if1.btn = 1'b0;
      wait_ticks(1);
      if1.btn = 1'b1;
      wait_ticks(1);
      check("cool_press_ign", 32'(if1.charging), 0);
      if1.btn = 1'b0;
      cyc(2);
      if1.btn = 1'b1;
      cyc(2);
      check("cool_end_idle", 32'(if1.charging), 0);
      cyc(1);
      check("rearm_charge", 32'(if1.charging), 1);

      // 4: turn_active gating
      if1.turn_active = 1'b0;
      cyc(1);
      check("ta_drop_chg", 32'(if1.charging), 0);
      check("ta_drop_force", 32'(if1.throw_force), 0);
      if1.btn = 1'b0;
      cyc(3);
      if1.btn = 1'b1;
      cyc(5);
      check("ta0_press", 32'(if1.charging), 0);
      if1.btn = 1'b0;
      if1.turn_active = 1'b1;
      cyc(3);
      if1.btn = 1'b1;
      cyc(3);
      check("ta1_press", 32'(if1.charging), 1);
      wait_ticks(3);
      check("ta_mid_force", 32'(if1.throw_force), 300);
      if1.turn_active = 1'b0;
      cyc(1);
      check("ta_mid_chg", 32'(if1.charging), 0);
      check("ta_mid_force0", 32'(if1.throw_force), 0);
      check("ta_mid_en", 32'(if1.enable), 0);
      if1.btn = 1'b0;
      cyc(4);
      check("ta_mid_no_throw", 32'(if1.enable), 0);

      // 5: step 300 sweep, release on a tick cycle
      if5.btn = 1'b1;
      cyc(3);
      check("s5_chg", 32'(if5.charging), 1);
      for (int i = 0; i < 14; i++) begin
         wait_ticks(1);
         check($sformatf("sweep5_%0d", i + 1), 32'(if5.throw_force), 32'(sweep5[i]));
      end
      cyc(1);
      if5.btn = 1'b0;
      cyc(2);
      check("s5_rel_lat2", 32'(if5.enable), 0);
      cyc(1);
      check("s5_rel_en", 32'(if5.enable), 1);
      check("s5_latched", 32'(if5.throw_force), 400);

      // 6: reset mid-flight and mid-charge
      cyc(2);
      rst = 1'b1;
      cyc(1);
      check("rstf_en", 32'(if5.enable), 0);
      check("rstf_force", 32'(if5.throw_force), 0);
      check("rstf_done", 32'(if5.throw_done), 0);
      cyc(1);
      check("rstf_done2", 32'(if5.throw_done), 0);
      rst = 1'b0;
      if1.turn_active = 1'b1;
      cyc(3);
      if1.btn = 1'b1;
      cyc(3);
      check("rstc_chg_pre", 32'(if1.charging), 1);
      cyc(1);
      rst = 1'b1;
      cyc(1);
      check("rstc_chg", 32'(if1.charging), 0);
      rst = 1'b0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/throw_force_meter.md
# throw_force_meter

Charge-and-release force meter for the player throw. While the player holds the fire button, the meter sweeps a 10-bit force value up and down between 0 and FORCE_MAX. On release it latches the value and asserts `enable` with a stable `throw_force` for a fixed flight window, then enforces a cooldown. Sits directly upstream of the throw trajectory controller: it drives that controller's `enable` and `throw_force` inputs, and its `charging` and `throw_force` outputs also feed the HUD power bar.

## Interface
Parameters:
- TICK_DIV, 65000: clk cycles per tick (1 ms at 65 MHz).
- FORCE_STEP, 2: force increment/decrement per tick while charging.
- FORCE_MAX, 1000: upper sweep limit; must be ≤ 1023.
- FLIGHT_TICKS, 3000: ticks `enable` stays high after release.
- COOLDOWN_TICKS, 500: ticks between end of flight and re-arm.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous reset, active-high.
- turn_active  in  1  1 = this player may throw.
- btn  in  1  raw fire button, asynchronous, 1 = pressed.
- throw_force  out  10  force value: sweeping during CHARGE, latched during FLIGHT, 0 otherwise.
- enable  out  1  throw request to the trajectory controller; high only in FLIGHT.
- charging  out  1  high in CHARGE.
- throw_done  out  1  one-cycle pulse when FLIGHT ends.

## Operation
- btn passes through a 2-flop synchronizer to `btn_s`. `btn_d` is `btn_s` delayed one cycle.
- Edge detect: rise = `btn_s & ~btn_d`; fall = `~btn_s & btn_d`.
- Tick counter counts 0..TICK_DIV-1 and runs freely. `tick` is high on the cycle the count equals TICK_DIV-1; the counter wraps to 0 on the next edge. Width is ceil(log2(TICK_DIV)).
- States: IDLE, CHARGE, FLIGHT, COOLDOWN.
- IDLE:
  - throw_force = 0.
  - rise && turn_active → CHARGE, with force = 0 and dir = up.
  - rise with turn_active = 0 is ignored.
- CHARGE, on tick:
  - dir up: next = force + FORCE_STEP, computed in 11 bits. If next ≥ FORCE_MAX, force = FORCE_MAX and dir = down.
  - dir down: if force ≤ FORCE_STEP, force = 0 and dir = up; else force = force − FORCE_STEP.
- CHARGE exits, in priority order:
  - turn_active = 0 → IDLE, force = 0, no throw.
  - fall → FLIGHT. force keeps its current value; any tick on that same cycle is ignored. enable = 1, flight count = 0.
- FLIGHT:
  - throw_force stays constant and enable = 1.
  - btn and turn_active are ignored.
  - Flight count increments on each tick. On the tick where the count equals FLIGHT_TICKS-1: go to COOLDOWN, set enable = 0, pulse throw_done for that one cycle, set count = 0.
- COOLDOWN:
  - throw_force = 0 and enable = 0.
  - On the tick where the count equals COOLDOWN_TICKS-1 → IDLE.
  - btn is ignored. A button held through COOLDOWN does not start a charge; a fresh rise in IDLE is required.
- Unreachable state encoding → IDLE.

## Timing
- Reset values: state IDLE, throw_force 0, enable 0, charging 0, throw_done 0. Tick, flight and cooldown counters 0, dir up, synchronizer flops 0.
- Reset asserted mid-operation (any state) returns all of the above on the next edge. enable drops within 1 cycle.
- btn transition to edge detection: 3 clk edges (2 sync + btn_d). The state change and registered outputs update on that 3rd edge.
- All outputs are registered; no combinational path from inputs to outputs.
- enable high duration: from the fall-detect edge to the FLIGHT_TICKS-th tick boundary. That is (FLIGHT_TICKS−1)·TICK_DIV + 1 to FLIGHT_TICKS·TICK_DIV cycles, depending on the tick phase at release.
- throw_force is stable for the whole time enable is high. It changes to 0 on the same edge enable falls.
- throw_done is high for exactly 1 cycle per throw, coincident with the first cycle enable = 0.

## Test plan
Use TICK_DIV=4, FORCE_STEP=100, FORCE_MAX=1000, FLIGHT_TICKS=5, COOLDOWN_TICKS=3.
1. Reset with btn=1 and turn_active=1 → all outputs 0. No CHARGE until btn falls and rises again after reset release.
2. Press and hold for 12 ticks → force 100, 200 … 1000 on tick 10, then 900, 800. Release → throw_force=800 and enable=1 three edges later, charging=0.
3. Flight then cooldown:
   - enable stays high through 5 ticks and throw_force stays 800 throughout.
   - throw_done pulses once as enable falls; throw_force goes to 0.
   - btn re-pressed during flight/cooldown → ignored.
   - After 3 cooldown ticks → IDLE, and a new press enters CHARGE.
4. turn_active=0: a press does nothing. turn_active drops mid-charge (force=300) → IDLE, force 0, enable never asserted.
5. FORCE_STEP=300, FORCE_MAX=1000 → sweep 300, 600, 900, 1000 (clamped), 700, 400, 100, 0, 300. Release on a tick cycle at force 400 → latched 400.
6. Reset asserted mid-FLIGHT → enable=0, throw_force=0, no throw_done pulse. Reset asserted mid-CHARGE → charging=0 next cycle.
